// File: rtl/uart_tx_if.sv
// Word handshake plus serial line between an upstream word source and uart_tx.
// Valid/ready: a word moves on any rising edge where data_in_req && ready are both high.
interface uart_tx_if #(
  parameter int WORD_SIZE = 8
);
  logic [WORD_SIZE-1:0] data_in;
  logic                 data_in_req;
  logic                 ready;
  logic                 tx;

  modport master (
    output data_in,
    output data_in_req,
    input  ready,
    input  tx
  );

  modport slave (
    input  data_in,
    input  data_in_req,
    output ready,
    output tx
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one start bit, WORD_SIZE data bits LSB first, one stop bit.
// Bit timing is a fixed CLKS_PER_BIT divider of clk; tx and ready are registered.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int WORD_SIZE    = 8
) (
  input  logic       clk,
  input  logic       n_reset,
  uart_tx_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 baud_done;
  logic                 bit_done;
  logic                 accept;

  assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign bit_done  = (bit_q == BIT_W'(WORD_SIZE - 1));
  assign accept    = bus.data_in_req && ready_q;

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign dbg_state = state_q;

  // tx and ready are computed for the next state so they change on the same edge as it.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (accept) begin
          state_d = START;
          shift_d = bus.data_in;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_done) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_d = IDLE;
          baud_d  = '0;
          tx_d    = 1'b1;
          ready_d = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts one WORD_SIZE-bit word per request and shifts it out on a single TX line as an 8N1-style frame (start bit, data bits LSB first, one stop bit). It sits directly downstream of the message disassembler (msg_disasm) in the test harness. The disassembler's `data_out`/`data_out_req` drive this block's `data_in`/`data_in_req`, and this block's `ready` drives the disassembler's `uart_ready`. Bit timing comes from the system clock through a fixed clocks-per-bit divider.

## Interface
- `CLKS_PER_BIT`, default 104: clk cycles per serial bit. Must be ≥ 2.
- `WORD_SIZE`, default 8: data bits per frame. Must be ≥ 1.

- `clk`  in  1  system clock; all logic on the rising edge.
- `n_reset`  in  1  synchronous, active-low reset.
- `data_in`  in  WORD_SIZE  word to transmit; sampled only on the accept edge.
- `data_in_req`  in  1  transmit request; the word is accepted on any edge where `data_in_req && ready`.
- `ready`  out  1  registered; high when idle and able to accept a word.
- `tx`  out  1  registered serial output; idles high.

## Operation
- States:
  - IDLE: `tx=1`, `ready=1`.
  - START: `tx=0`.
  - DATA: `tx` = current shift bit.
  - STOP: `tx=1`.
  - `ready=0` in every state other than IDLE.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1.
  - Bit counter is $clog2(WORD_SIZE) bits wide, minimum 1 bit.
  - Both counters reset to 0, and both clear on accept.
- Transitions:
  - IDLE→START on the accept edge. On this edge `data_in` is loaded into the shift register, `tx` is driven to 0 and `ready` is driven to 0.
  - START→DATA when the baud counter reaches CLKS_PER_BIT-1.
  - DATA: at each baud terminal count the shift register shifts right and the bit counter increments. After bit WORD_SIZE-1 completes, go to STOP.
  - STOP→IDLE at the baud terminal count. `ready` returns to 1 on the same edge.
- Data is captured on the accept edge, so changes on `data_in` after that edge do not affect the frame in progress.
- `data_in_req` while `ready=0` is ignored. No queuing, no error flag.
- `data_in_req` may be held high continuously. Each IDLE cycle with `req` high starts a new frame.
- Reset has priority over everything, including mid-frame. On the next edge: state=IDLE, `tx=1`, `ready=1`, counters=0, shift register=0. A partial frame is abandoned and not resumed.

## Timing
- Let accept edge = E0, C = CLKS_PER_BIT, W = WORD_SIZE.
- Start bit: `tx=0` for the cycles after edges E0 .. E0+C-1.
- Data bit i (LSB first): driven for edges E0+(1+i)C .. E0+(2+i)C-1.
- Stop bit: driven for edges E0+(W+1)C .. E0+(W+2)C-1.
- At edge E0+(W+2)C: state=IDLE, `ready=1`.
- Earliest next accept is edge E0+(W+2)C+1. Minimum accept-to-accept spacing is (W+2)C+1 cycles, with exactly one idle-high cycle between back-to-back frames.
- `ready` falls on the accept edge itself. An upstream stage that forms its request combinationally from `ready` therefore sees `ready=0` in the following cycle and cannot issue a double request.
- Values after reset: `tx=1`, `ready=1`.

## Test plan
- Reset, then idle with `req=0` for 100 cycles: `tx=1` and `ready=1` throughout.
- C=4, W=8, send 0xA5 with a single-cycle `req`:
  - `tx` reads 0 | 1,0,1,0,0,1,0,1 | 1, each value for exactly 4 cycles.
  - `ready` is low for exactly 40 cycles starting at the accept edge.
- Hold `req=1` continuously with `data_in` alternating 0x00 and 0xFF:
  - Two complete frames are sent, accept edges 41 cycles apart.
  - There is exactly one idle-high cycle between the frames.
- Pulse `req` with 0x3C in the middle of a frame carrying 0x81: the 0x81 frame completes unchanged and no 0x3C frame is ever sent.
- Change `data_in` every cycle after accepting 0x5A: the transmitted bits still decode as 0x5A.
- Assert `n_reset` for 1 cycle during data bit 3:
  - `tx=1` and `ready=1` on the next edge.
  - A new request for 0x12 then produces a correct full frame.
